alu_seq_core: RTL and testbench
===============================

Name: alu_seq_core

Overview:
- Parametrised, sequential successor to the 8-bit TinyTapeout ALU datapath.
- Holds two WIDTH-bit operand registers, loaded one at a time from a shared input bus.
- Executes an operation on a start strobe and returns a registered result with flags, a busy signal and a one-cycle done pulse.
- Shifts are multi-cycle (one bit per cycle) unless the barrel-shift option is compiled in. The block sits between the pad-level top (ui_in/uio_in) and the flag/7-segment display logic.

Parameters:
- WIDTH, 8, operand/result width; power of two, at least 4.
- SHAMT_W, $clog2(WIDTH), shift-amount width (derived; do not override).

Ports:
- clk  in  1  single system clock
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  global enable; when low, load, start and FSM advance are all frozen
- load  in  1  operand load strobe
- sel_b  in  1  load target: 0 = A, 1 = B
- din  in  WIDTH  operand data
- start  in  1  start-operation strobe
- op  in  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR (logical), 111 SRA
- shamt  in  SHAMT_W  shift amount; used for shift opcodes only
- busy  out  1  high while an operation is executing
- done  out  1  one-cycle completion pulse
- y  out  WIDTH  registered result
- carry  out  1  carry/borrow/last-bit-out flag
- zero  out  1  y == 0
- neg  out  1  y[WIDTH-1]
- overflow  out  1  signed overflow

Behaviour:
- Reset (async, rst_n low):
  - reg_a, reg_b, y and all flags go to 0.
  - done = 0, busy = 0, FSM state = IDLE.
  - Reset in mid-operation aborts the operation with no done pulse.
- Operand load:
  - On a clk edge with ena & load & !busy, din is written to A (sel_b = 0) or B (sel_b = 1).
  - load while busy is ignored.
- FSM states are IDLE and EXEC; busy = (state == EXEC).
- IDLE:
  - On an edge with ena & start, op and shamt are latched, a working register is set to reg_a, a shift counter is set to shamt, and the FSM moves to EXEC.
  - If load and start occur in the same cycle, start uses the pre-load operand values.
- EXEC, non-shift op (latency 1):
  - On the next enabled edge, y and the flags are written, done pulses for one cycle, and the FSM returns to IDLE.
- EXEC, shift op:
  - If counter == 0, y = working register and the operation completes as above.
  - Otherwise, each enabled edge shifts the working register by one bit and decrements the counter.
  - Total latency from the start edge to the done edge is shamt+1 cycles; shamt = 0 gives y = A.
- start while busy is ignored.
- ena low: the state, counter and working register hold. done still deasserts on the next edge (it is never stretched).
- Arithmetic:
  - ADD: carry = carry-out.
  - SUB: A-B; carry = borrow (1 when A < B unsigned).
  - ADD/SUB overflow follows the standard two's-complement rules.
  - AND/OR/XOR: carry = 0, overflow = 0.
  - Shifts: carry = last bit shifted out (0 if shamt = 0), overflow = 0.
  - SHL and SHR fill with 0; SRA replicates the MSB.
- zero and neg are computed from the new y value.
- All flags update only on completion and hold until the next completion.

Optional Feature:
- Macro: ALU_BARREL_SHIFT_EN.
- Defined: shifts complete in one EXEC cycle like the other ops (latency 1). carry = the last bit shifted out, i.e. the bit at index WIDTH-shamt of A for SHL, and the bit at index shamt-1 of A for SHR/SRA; carry = 0 when shamt = 0. The shift counter logic is omitted.
- Undefined: the iterative shifting described above.

Decomposition:
- Package alu_pkg holds:
  - op_e enum with the 3-bit encodings above;
  - state_e enum (IDLE, EXEC);
  - a localparam helper for flag bit positions, shared with the display logic.
- Sub-module alu_operand_regs holds the A/B registers and the load/sel_b/busy gating. The FSM, datapath and flags live in alu_seq_core.

Test Plan (WIDTH = 8):
- ADD: load A = 0x7F, B = 0x01, start op = 000 → after 1 cycle y = 0x80, overflow = 1, neg = 1, carry = 0, zero = 0, and done is high for exactly 1 cycle.
- SUB: A = 0x05, B = 0x07, op = 001 → y = 0xFE, carry = 1, neg = 1, overflow = 0. Then A = 0x07, B = 0x07 → y = 0x00, zero = 1, carry = 0.
- SHL: A = 0x81, shamt = 3, op = 101 → busy for 4 cycles, then y = 0x08, carry = 0. With ALU_BARREL_SHIFT_EN the same stimulus gives done after 1 cycle with identical y and carry.
- SRA: A = 0x80, shamt = 7, op = 111 → y = 0xFF, neg = 1, carry = 0, done 8 cycles after start. shamt = 0 → y = 0x80 after 1 cycle, carry = 0.
- Interference: during a busy shift, pulse start (op = ADD) and load (sel_b = 0, din = 0x55) → both ignored, and the original shift result is unchanged. Holding ena low for 3 cycles mid-shift extends the latency by exactly 3 cycles.
- Reset: assert rst_n low mid-shift → busy = 0, y = 0, all flags 0, and no done pulse. A fresh ADD after reset with operands reloaded works normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcodes, FSM states and flag bit positions.
// Flag positions are also consumed by the flag/7-segment display logic.
package alu_pkg;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_XOR = 3'b100,
      OP_SHL = 3'b101,
      OP_SHR = 3'b110,
      OP_SRA = 3'b111
   } op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_EXEC = 1'b1
   } state_e;

   localparam int FLAG_CARRY = 0;
   localparam int FLAG_ZERO  = 1;
   localparam int FLAG_NEG   = 2;
   localparam int FLAG_OVF   = 3;
   localparam int FLAG_W     = 4;

   function automatic logic is_shift_op(input op_e o);
      return (o == OP_SHL) || (o == OP_SHR) || (o == OP_SRA);
   endfunction

endpackage

// File: rtl/alu_operand_regs.sv
// Operand A/B registers loaded from the shared din bus.
// Loads are frozen while ena is low or an operation is in flight.
module alu_operand_regs
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic             load,
   input  logic             sel_b,
   input  logic             busy,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] reg_a,
   output logic [WIDTH-1:0] reg_b
);

   logic load_ok;

   assign load_ok = ena & load & ~busy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         reg_a <= '0;
         reg_b <= '0;
      end else if (load_ok) begin
         if (sel_b) reg_b <= din;
         else       reg_a <= din;
      end
   end

endmodule

// File: rtl/alu_seq_core.sv
// Sequential ALU core: operand registers, IDLE/EXEC FSM, datapath and result flags.
// Define ALU_BARREL_SHIFT_EN for single-cycle shifts; otherwise shifts step one bit per cycle.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | waiting for start; operands may be loaded
// ST_EXEC | operation in flight; shifts iterate here until the count hits 0
module alu_seq_core
   import alu_pkg::*;
#(
   parameter  int WIDTH   = 8,
   localparam int SHAMT_W = $clog2(WIDTH)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               ena,
   input  logic               load,
   input  logic               sel_b,
   input  logic [WIDTH-1:0]   din,
   input  logic               start,
   input  logic [2:0]         op,
   input  logic [SHAMT_W-1:0] shamt,
   output logic               busy,
   output logic               done,
   output logic [WIDTH-1:0]   y,
   output logic               carry,
   output logic               zero,
   output logic               neg,
   output logic               overflow
);

   localparam int MSB = WIDTH - 1;

   logic [WIDTH-1:0] reg_a, reg_b;
   state_e           state_q, state_d;
   op_e              op_q;
   logic [WIDTH-1:0] work_q, opb_q;
   logic             start_acc, complete;
   logic [WIDTH:0]   sum_ext, dif_ext;
   logic [WIDTH-1:0] res_y;
   logic             res_c, res_v;
`ifdef ALU_BARREL_SHIFT_EN
   logic [SHAMT_W-1:0] shamt_q;
   logic [WIDTH:0]     shl_ext, shr_ext, sra_ext;
`else
   logic [SHAMT_W-1:0] cnt_q;
   logic               sh_c_q;
   logic               shift_step;
`endif

   alu_operand_regs #(.WIDTH(WIDTH)) u_operand_regs (
      .clk   (clk),
      .rst_n (rst_n),
      .ena   (ena),
      .load  (load),
      .sel_b (sel_b),
      .busy  (busy),
      .din   (din),
      .reg_a (reg_a),
      .reg_b (reg_b)
   );

   assign busy = (state_q == ST_EXEC);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      start_acc = 1'b0;
      complete  = 1'b0;
`ifndef ALU_BARREL_SHIFT_EN
      shift_step = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (ena && start) begin
               start_acc = 1'b1;
               state_d   = ST_EXEC;
            end
         end
         ST_EXEC: begin
            if (ena) begin
`ifdef ALU_BARREL_SHIFT_EN
               complete = 1'b1;
               state_d  = ST_IDLE;
`else
               if (is_shift_op(op_q) && (cnt_q != '0)) begin
                  shift_step = 1'b1;
               end else begin
                  complete = 1'b1;
                  state_d  = ST_IDLE;
               end
`endif
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Shift carry comes from an extra guard bit so shamt = 0 naturally yields 0.
   always_comb begin
      sum_ext = {1'b0, work_q} + {1'b0, opb_q};
      dif_ext = {1'b0, work_q} - {1'b0, opb_q};
      res_y   = work_q;
      res_c   = 1'b0;
      res_v   = 1'b0;
`ifdef ALU_BARREL_SHIFT_EN
      shl_ext = {1'b0, work_q} << shamt_q;
      shr_ext = {work_q, 1'b0} >> shamt_q;
      sra_ext = $signed({work_q, 1'b0}) >>> shamt_q;
`endif
      case (op_q)
         OP_ADD: begin
            res_y = sum_ext[MSB:0];
            res_c = sum_ext[WIDTH];
            res_v = (work_q[MSB] == opb_q[MSB]) && (sum_ext[MSB] != work_q[MSB]);
         end
         OP_SUB: begin
            res_y = dif_ext[MSB:0];
            res_c = dif_ext[WIDTH];
            res_v = (work_q[MSB] != opb_q[MSB]) && (dif_ext[MSB] != work_q[MSB]);
         end
         OP_AND: res_y = work_q & opb_q;
         OP_OR:  res_y = work_q | opb_q;
         OP_XOR: res_y = work_q ^ opb_q;
`ifdef ALU_BARREL_SHIFT_EN
         OP_SHL: begin res_y = shl_ext[MSB:0];   res_c = shl_ext[WIDTH]; end
         OP_SHR: begin res_y = shr_ext[WIDTH:1]; res_c = shr_ext[0];     end
         OP_SRA: begin res_y = sra_ext[WIDTH:1]; res_c = sra_ext[0];     end
`else
         OP_SHL, OP_SHR, OP_SRA: res_c = sh_c_q;
`endif
         default: res_y = work_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q     <= OP_ADD;
         work_q   <= '0;
         opb_q    <= '0;
         done     <= 1'b0;
         y        <= '0;
         carry    <= 1'b0;
         zero     <= 1'b0;
         neg      <= 1'b0;
         overflow <= 1'b0;
`ifdef ALU_BARREL_SHIFT_EN
         shamt_q  <= '0;
`else
         cnt_q    <= '0;
         sh_c_q   <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         // Both operands are captured so a same-cycle load cannot leak into this op.
         if (start_acc) begin
            op_q   <= op_e'(op);
            work_q <= reg_a;
            opb_q  <= reg_b;
`ifdef ALU_BARREL_SHIFT_EN
            shamt_q <= shamt;
`else
            cnt_q  <= shamt;
            sh_c_q <= 1'b0;
`endif
         end
`ifndef ALU_BARREL_SHIFT_EN
         if (shift_step) begin
            cnt_q <= cnt_q - SHAMT_W'(1);
            case (op_q)
               OP_SHL: begin work_q <= {work_q[MSB-1:0], 1'b0};   sh_c_q <= work_q[MSB]; end
               OP_SHR: begin work_q <= {1'b0, work_q[MSB:1]};     sh_c_q <= work_q[0];   end
               OP_SRA: begin work_q <= {work_q[MSB], work_q[MSB:1]}; sh_c_q <= work_q[0]; end
               default: begin end
            endcase
         end
`endif
         if (complete) begin
            y        <= res_y;
            carry    <= res_c;
            zero     <= (res_y == '0);
            neg      <= res_y[MSB];
            overflow <= res_v;
            done     <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_alu_seq_core.sv
// Scoreboard bench for alu_seq_core (WIDTH = 8): directed ops push expectations,
// a monitor pops and compares on every done pulse, including start-to-done latency.
module tb_alu_seq_core;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       ena = 1'b1;
   logic       load = 1'b0;
   logic       sel_b = 1'b0;
   logic [7:0] din = '0;
   logic       start = 1'b0;
   logic [2:0] op = '0;
   logic [2:0] shamt = '0;
   logic       busy, done, carry, zero, neg, overflow;
   logic [7:0] y;

   typedef struct {
      string      nm;
      logic [7:0] y;
      logic       c, z, n, v;
      int         t0;
      int         lat;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc = 0;

   alu_seq_core #(.WIDTH(8)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .ena      (ena),
      .load     (load),
      .sel_b    (sel_b),
      .din      (din),
      .start    (start),
      .op       (op),
      .shamt    (shamt),
      .busy     (busy),
      .done     (done),
      .y        (y),
      .carry    (carry),
      .zero     (zero),
      .neg      (neg),
      .overflow (overflow)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (done) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            chk({mon_e.nm, ".y"},   {24'd0, y},        {24'd0, mon_e.y});
            chk({mon_e.nm, ".c"},   {31'd0, carry},    {31'd0, mon_e.c});
            chk({mon_e.nm, ".z"},   {31'd0, zero},     {31'd0, mon_e.z});
            chk({mon_e.nm, ".n"},   {31'd0, neg},      {31'd0, mon_e.n});
            chk({mon_e.nm, ".v"},   {31'd0, overflow}, {31'd0, mon_e.v});
            chk({mon_e.nm, ".lat"}, 32'(cyc - mon_e.t0), 32'(mon_e.lat));
         end
      end
   end

   function automatic int shift_lat(input logic [2:0] sh);
`ifdef ALU_BARREL_SHIFT_EN
      return 1;
`else
      return int'(sh) + 1;
`endif
   endfunction

   task automatic push(input string nm, input logic [7:0] ey, input logic ec, ez, en, ev,
                       input int lat);
      exp_t e;
      e.nm = nm; e.y = ey; e.c = ec; e.z = ez; e.n = en; e.v = ev;
      e.t0 = cyc + 1; e.lat = lat;
      exp_q.push_back(e);
   endtask

   task automatic load_op(input logic sb, input logic [7:0] d);
      @(negedge clk);
      load = 1'b1; sel_b = sb; din = d;
      @(negedge clk);
      load = 1'b0;
   endtask

   task automatic wait_idle(input string nm);
      int k;
      k = 0;
      while (busy && k < 64) begin
         @(negedge clk);
         k++;
      end
      chk({nm, ".timeout"}, {31'd0, busy}, 32'd0);
   endtask

   task automatic run_op(input string nm, input logic [2:0] o, input logic [2:0] sh,
                         input logic [7:0] ey, input logic ec, ez, en, ev);
      int lat;
      lat = (o >= 3'd5) ? shift_lat(sh) : 1;
      @(negedge clk);
      op = o; shamt = sh; start = 1'b1;
      push(nm, ey, ec, ez, en, ev, lat);
      @(negedge clk);
      start = 1'b0;
      wait_idle(nm);
   endtask

   initial begin
      #3 rst_n = 1'b0;
      #1;
      chk("rst.busy", {31'd0, busy}, 32'd0);
      chk("rst.done", {31'd0, done}, 32'd0);
      chk("rst.y", {24'd0, y}, 32'd0);
      chk("rst.flags", {28'd0, carry, zero, neg, overflow}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      load_op(1'b0, 8'h7F); load_op(1'b1, 8'h01);
      run_op("add_ovf", 3'b000, 3'd0, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1);

      load_op(1'b0, 8'h05); load_op(1'b1, 8'h07);
      run_op("sub_borrow", 3'b001, 3'd0, 8'hFE, 1'b1, 1'b0, 1'b1, 1'b0);
      load_op(1'b0, 8'h07);
      run_op("sub_zero", 3'b001, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);

      load_op(1'b0, 8'hF0); load_op(1'b1, 8'h3C);
      run_op("and", 3'b010, 3'd0, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0);
      run_op("or",  3'b011, 3'd0, 8'hFC, 1'b0, 1'b0, 1'b1, 1'b0);
      run_op("xor", 3'b100, 3'd0, 8'hCC, 1'b0, 1'b0, 1'b1, 1'b0);

      load_op(1'b0, 8'hFF); load_op(1'b1, 8'h01);
      run_op("add_carry", 3'b000, 3'd0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
      load_op(1'b0, 8'h80);
      run_op("sub_ovf", 3'b001, 3'd0, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b1);

      load_op(1'b0, 8'h81);
      run_op("shl3", 3'b101, 3'd3, 8'h08, 1'b0, 1'b0, 1'b0, 1'b0);
      load_op(1'b0, 8'h80);
      run_op("sra7", 3'b111, 3'd7, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0);
      run_op("sra0", 3'b111, 3'd0, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0);

      // start and load pulsed while busy must both be ignored
      load_op(1'b0, 8'hB4); load_op(1'b1, 8'hFF);
      @(negedge clk);
      op = 3'b110; shamt = 3'd3; start = 1'b1;
      push("shr3_interf", 8'h16, 1'b1, 1'b0, 1'b0, 1'b0, shift_lat(3'd3));
      @(negedge clk);
      op = 3'b000; load = 1'b1; sel_b = 1'b0; din = 8'h55;
      @(negedge clk);
      start = 1'b0; load = 1'b0;
      wait_idle("shr3_interf");
      run_op("and_a_kept", 3'b010, 3'd0, 8'hB4, 1'b0, 1'b0, 1'b1, 1'b0);

      // ena low for 3 cycles while executing stretches latency by 3
      @(negedge clk);
      op = 3'b101; shamt = 3'd3; start = 1'b1;
      push("shl3_ena", 8'hA0, 1'b1, 1'b0, 1'b1, 1'b0, shift_lat(3'd3) + 3);
      @(negedge clk);
      start = 1'b0; ena = 1'b0;
      repeat (3) @(negedge clk);
      ena = 1'b1;
      wait_idle("shl3_ena");

      // same-cycle load and start: op sees the old A
      load_op(1'b0, 8'h10); load_op(1'b1, 8'h01);
      @(negedge clk);
      op = 3'b000; start = 1'b1; load = 1'b1; sel_b = 1'b0; din = 8'h20;
      push("add_preload", 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1);
      @(negedge clk);
      start = 1'b0; load = 1'b0;
      wait_idle("add_preload");
      run_op("add_postload", 3'b000, 3'd0, 8'h21, 1'b0, 1'b0, 1'b0, 1'b0);

      load_op(1'b0, 8'hC0); load_op(1'b1, 8'hC0);
      run_op("add_neg", 3'b000, 3'd0, 8'h80, 1'b1, 1'b0, 1'b1, 1'b0);

      // reset mid-operation: no done, everything cleared
      @(negedge clk);
      op = 3'b111; shamt = 3'd7; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("midrst.busy_before", {31'd0, busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("midrst.busy", {31'd0, busy}, 32'd0);
      chk("midrst.done", {31'd0, done}, 32'd0);
      chk("midrst.y", {24'd0, y}, 32'd0);
      chk("midrst.flags", {28'd0, carry, zero, neg, overflow}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      chk("midrst.idle", {31'd0, busy}, 32'd0);

      load_op(1'b0, 8'h12); load_op(1'b1, 8'h34);
      run_op("add_after_rst", 3'b000, 3'd0, 8'h46, 1'b0, 1'b0, 1'b0, 1'b0);

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
